// File: rtl/avalon_mem_checker_pkg.sv
// Shared types and helpers for the Avalon-MM memory BIST (avalon_mem_checker).
package avalon_mem_checker_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ,
        ST_DRAIN,
        ST_FINISH
    } state_e;

    localparam logic [31:0] LFSR_POLY   = 32'h8020_0003;
    localparam int          ERR_COUNT_W = 16;

    // Galois step for x^32+x^22+x^2+x+1, shifting right.
    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return {1'b0, s[31:1]} ^ (s[0] ? LFSR_POLY : 32'h0);
    endfunction

endpackage

// File: rtl/avalon_mem_checker_if.sv
// Avalon-MM bus between the memory checker (master) and the on-chip RAM s2 port (slave).
interface avalon_mem_checker_if #(
    parameter int ADDR_WIDTH = 9
);
    logic [ADDR_WIDTH-1:0] m_address;
    logic [3:0]            m_byteenable;
    logic                  m_chipselect;
    logic                  m_write;
    logic [31:0]           m_writedata;
    logic [31:0]           m_readdata;
    logic                  m_clken;

    modport master (
        output m_address, m_byteenable, m_chipselect, m_write, m_writedata, m_clken,
        input  m_readdata
    );

    modport slave (
        input  m_address, m_byteenable, m_chipselect, m_write, m_writedata, m_clken,
        output m_readdata
    );
endinterface

// File: rtl/avalon_mem_checker_delay.sv
// DEPTH-stage shift register carrying {valid, addr, expected} alongside in-flight reads.
module avalon_mem_checker_delay #(
    parameter int DEPTH = 1,
    parameter int AW    = 9
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          in_vld,
    input  logic [AW-1:0] in_addr,
    input  logic [31:0]   in_data,
    output logic          out_vld,
    output logic [AW-1:0] out_addr,
    output logic [31:0]   out_data
);
    logic [DEPTH:1]         vld_pipe;
    logic [DEPTH:1][AW-1:0] addr_pipe;
    logic [DEPTH:1][31:0]   data_pipe;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_pipe  <= '0;
            addr_pipe <= '0;
            data_pipe <= '0;
        end else begin
            vld_pipe[1]  <= in_vld;
            addr_pipe[1] <= in_addr;
            data_pipe[1] <= in_data;
            for (int i = 2; i <= DEPTH; i++) begin
                vld_pipe[i]  <= vld_pipe[i-1];
                addr_pipe[i] <= addr_pipe[i-1];
                data_pipe[i] <= data_pipe[i-1];
            end
        end
    end

    assign out_vld  = vld_pipe[DEPTH];
    assign out_addr = addr_pipe[DEPTH];
    assign out_data = data_pipe[DEPTH];
endmodule

// File: rtl/avalon_mem_checker.sv
// Memory BIST master: LFSR fill, read-back compare, pass/fail with error count.
// Define AVALON_MEM_CHECKER_ERR_CAPTURE_EN to keep the first-error address/data registers.
module avalon_mem_checker
    import avalon_mem_checker_pkg::*;
#(
    parameter int ADDR_WIDTH   = 9,
    parameter int READ_LATENCY = 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic [31:0]            seed,
    input  logic [ADDR_WIDTH:0]    word_count,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [ERR_COUNT_W-1:0] err_count,
    output logic [ADDR_WIDTH-1:0]  first_err_addr,
    output logic [31:0]            first_err_data,
    avalon_mem_checker_if.master   mem
);
    localparam logic [ADDR_WIDTH:0] WINDOW     = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam int                  DW         = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam logic [DW-1:0]       DRAIN_LAST = DW'(READ_LATENCY - 1);

    state_e                  state_q, state_d;
    logic [31:0]             lfsr_q, lfsr_d, seed_q, seed_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [ADDR_WIDTH:0]     count_q, count_d;
    logic [DW-1:0]           drain_q, drain_d;
    logic [ERR_COUNT_W-1:0]  err_count_q, err_count_d;
    logic                    pass_q, pass_d;

    logic                    start_acc, last_addr, mismatch;
    logic [31:0]             seed_eff;
    logic [ADDR_WIDTH:0]     wc_eff;
    logic                    dly_vld;
    logic [ADDR_WIDTH-1:0]   dly_addr;
    logic [31:0]             dly_data;

    // A zero seed would lock the LFSR at zero, so it is promoted to 1.
    assign seed_eff  = (seed == '0) ? 32'd1 : seed;
    assign wc_eff    = (word_count > WINDOW) ? WINDOW : word_count;
    assign start_acc = (state_q == ST_IDLE) && start;
    assign last_addr = ({1'b0, addr_q} == count_q - 1'b1);
    assign mismatch  = dly_vld && (mem.m_readdata != dly_data);

    avalon_mem_checker_delay #(.DEPTH(READ_LATENCY), .AW(ADDR_WIDTH)) u_delay (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_vld   (state_q == ST_READ),
        .in_addr  (addr_q),
        .in_data  (lfsr_q),
        .out_vld  (dly_vld),
        .out_addr (dly_addr),
        .out_data (dly_data)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start) state_d = (wc_eff == '0) ? ST_FINISH : ST_WRITE;
            ST_WRITE:  if (last_addr) state_d = ST_READ;
            ST_READ:   if (last_addr) state_d = ST_DRAIN;
            ST_DRAIN:  if (drain_q == DRAIN_LAST) state_d = ST_FINISH;
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        mem.m_chipselect = 1'b0;
        mem.m_write      = 1'b0;
        mem.m_address    = '0;
        mem.m_writedata  = '0;
        busy             = (state_q != ST_IDLE);
        done             = 1'b0;
        pass             = pass_q;
        case (state_q)
            ST_WRITE: begin
                mem.m_chipselect = 1'b1;
                mem.m_write      = 1'b1;
                mem.m_address    = addr_q;
                mem.m_writedata  = lfsr_q;
            end
            ST_READ: begin
                mem.m_chipselect = 1'b1;
                mem.m_address    = addr_q;
            end
            ST_FINISH: begin
                done = 1'b1;
                pass = (err_count_q == '0);
            end
            default: ;
        endcase
    end

    assign mem.m_byteenable = 4'hF;
    assign mem.m_clken      = 1'b1;
    assign err_count        = err_count_q;

    always_comb begin
        lfsr_d      = lfsr_q;
        seed_d      = seed_q;
        addr_d      = addr_q;
        count_d     = count_q;
        drain_d     = drain_q;
        err_count_d = err_count_q;
        pass_d      = pass_q;
        case (state_q)
            ST_IDLE: if (start) begin
                seed_d      = seed_eff;
                lfsr_d      = seed_eff;
                addr_d      = '0;
                count_d     = wc_eff;
                err_count_d = '0;
                pass_d      = 1'b0;
            end
            // Rewind the pattern at the end of the fill so reads regenerate it in order.
            ST_WRITE: if (last_addr) begin
                lfsr_d = seed_q;
                addr_d = '0;
            end else begin
                lfsr_d = lfsr_next(lfsr_q);
                addr_d = addr_q + 1'b1;
            end
            ST_READ: begin
                lfsr_d  = lfsr_next(lfsr_q);
                addr_d  = addr_q + 1'b1;
                drain_d = '0;
            end
            ST_DRAIN:  drain_d = drain_q + 1'b1;
            ST_FINISH: pass_d  = (err_count_q == '0);
            default: ;
        endcase
        if (mismatch && err_count_q != '1) err_count_d = err_count_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lfsr_q      <= '0;
            seed_q      <= '0;
            addr_q      <= '0;
            count_q     <= '0;
            drain_q     <= '0;
            err_count_q <= '0;
            pass_q      <= 1'b0;
        end else begin
            lfsr_q      <= lfsr_d;
            seed_q      <= seed_d;
            addr_q      <= addr_d;
            count_q     <= count_d;
            drain_q     <= drain_d;
            err_count_q <= err_count_d;
            pass_q      <= pass_d;
        end
    end

`ifdef AVALON_MEM_CHECKER_ERR_CAPTURE_EN
    logic [ADDR_WIDTH-1:0] first_err_addr_q, first_err_addr_d;
    logic [31:0]           first_err_data_q, first_err_data_d;

    // The count is still zero on the cycle of the first mismatch.
    always_comb begin
        first_err_addr_d = first_err_addr_q;
        first_err_data_d = first_err_data_q;
        if (start_acc) begin
            first_err_addr_d = '0;
            first_err_data_d = '0;
        end else if (mismatch && err_count_q == '0) begin
            first_err_addr_d = dly_addr;
            first_err_data_d = mem.m_readdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            first_err_addr_q <= '0;
            first_err_data_q <= '0;
        end else begin
            first_err_addr_q <= first_err_addr_d;
            first_err_data_q <= first_err_data_d;
        end
    end

    assign first_err_addr = first_err_addr_q;
    assign first_err_data = first_err_data_q;
`else
    logic unused_dly_addr;
    assign unused_dly_addr = ^{dly_addr, start_acc};
    assign first_err_addr  = '0;
    assign first_err_data  = '0;
`endif
endmodule

// File: tb/tb_avalon_mem_checker.sv
// Randomized self-checking bench for avalon_mem_checker against RAM models with fault injection.
module tb_avalon_mem_checker;
    localparam int AW  = 9;
    localparam int AW3 = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_step(input logic [31:0] s);
        return (s >> 1) ^ ({32{s[0]}} & 32'h8020_0003);
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] sd, input int idx);
        logic [31:0] s;
        s = (sd == 0) ? 32'd1 : sd;
        for (int i = 0; i < idx; i++) s = ref_step(s);
        return s;
    endfunction

    // ---------------- DUT 1: L=1, 512-word window ----------------
    logic          start1 = 1'b0;
    logic [31:0]   seed1 = '0;
    logic [AW:0]   wc1 = '0;
    logic          busy1, done1, pass1;
    logic [15:0]   err1;
    logic [AW-1:0] fea1;
    logic [31:0]   fed1;

    avalon_mem_checker_if #(.ADDR_WIDTH(AW)) bus1 ();

    avalon_mem_checker #(.ADDR_WIDTH(AW), .READ_LATENCY(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .start(start1), .seed(seed1), .word_count(wc1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
        .first_err_addr(fea1), .first_err_data(fed1), .mem(bus1)
    );

    bit   [31:0] mem1 [512];
    logic [31:0] rd1_q = '0;
    int          mode1 = 0;

    always @(posedge clk) begin
        if (bus1.m_chipselect && bus1.m_write)
            mem1[bus1.m_address] <= (mode1 == 1 && bus1.m_address == 9'h07F) ?
                                    (bus1.m_writedata & ~32'h20) : bus1.m_writedata;
        rd1_q <= (mode1 == 2) ? 32'h0 : mem1[bus1.m_address];
    end
    assign bus1.m_readdata = rd1_q;

    logic [31:0] exp_w [512];
    int wr_cnt = 0, rd_cnt = 0, bus_bad = 0, done_cnt1 = 0;
    int wr_base = 0, rd_base = 0;

    always @(negedge clk) begin
        if (bus1.m_chipselect) begin
            if (bus1.m_byteenable != 4'hF) bus_bad++;
            if (bus1.m_write) begin
                if ((wr_cnt - wr_base) >= 512 || int'(bus1.m_address) != wr_cnt - wr_base ||
                    bus1.m_writedata != exp_w[wr_cnt - wr_base]) bus_bad++;
                wr_cnt++;
            end else begin
                if (int'(bus1.m_address) != rd_cnt - rd_base) bus_bad++;
                rd_cnt++;
            end
        end
        if (done1) done_cnt1++;
    end

    task automatic run1(input logic [31:0] sd, input int wc, input int mode,
                        input bit sat, input string tag);
        int n, e_err, e_fa, cyc, bb0, dc0;
        logic [31:0] s, rd, e_fd;
        bit seen;
        n = (wc > 512) ? 512 : wc;
        s = (sd == 0) ? 32'd1 : sd;
        for (int i = 0; i < n; i++) begin
            exp_w[i] = s;
            s = ref_step(s);
        end
        e_err = sat ? 32'hFFFE : 0;
        e_fa = 0; e_fd = 0; seen = 0;
        for (int i = 0; i < n; i++) begin
            rd = (mode == 2) ? 32'h0 : (mode == 1 && i == 127) ? (exp_w[i] & ~32'h20) : exp_w[i];
            if (rd != exp_w[i]) begin
                if (e_err < 32'hFFFF) e_err++;
                if (!seen) begin seen = 1; e_fa = i; e_fd = rd; end
            end
        end
        @(negedge clk);
        mode1 = mode; wr_base = wr_cnt; rd_base = rd_cnt; bb0 = bus_bad; dc0 = done_cnt1;
        seed1 = sd; wc1 = wc[AW:0]; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0; cyc = 1;
        while (!done1 && cyc < 2 * n + 20) begin
            if (sat && cyc == n + 1) begin
                force dut1.err_count_q = 16'hFFFE;
                #1 release dut1.err_count_q;
            end
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_done_cyc"}, cyc, (n == 0) ? 1 : 2 * n + 2);
        chk({tag, "_pass"}, pass1, (e_err == 0));
        chk({tag, "_err_count"}, err1, e_err);
`ifdef AVALON_MEM_CHECKER_ERR_CAPTURE_EN
        if (!sat) begin
            chk({tag, "_first_addr"}, fea1, e_fa);
            chk({tag, "_first_data"}, fed1, e_fd);
        end
`else
        chk({tag, "_first_addr"}, fea1, 0);
        chk({tag, "_first_data"}, fed1, 0);
`endif
        @(negedge clk);
        chk({tag, "_busy_after"}, busy1, 0);
        chk({tag, "_pass_held"}, pass1, (e_err == 0));
        chk({tag, "_writes"}, wr_cnt - wr_base, n);
        chk({tag, "_reads"}, rd_cnt - rd_base, n);
        chk({tag, "_bus_seq"}, bus_bad - bb0, 0);
        chk({tag, "_done_pulses"}, done_cnt1 - dc0, 1);
    endtask

    // ---------------- DUT 3: L=3, 16-word window ----------------
    logic           start3 = 1'b0;
    logic [31:0]    seed3 = '0;
    logic [AW3:0]   wc3 = '0;
    logic           busy3, done3, pass3;
    logic [15:0]    err3;
    logic [AW3-1:0] fea3;
    logic [31:0]    fed3;

    avalon_mem_checker_if #(.ADDR_WIDTH(AW3)) bus3 ();

    avalon_mem_checker #(.ADDR_WIDTH(AW3), .READ_LATENCY(3)) dut3 (
        .clk(clk), .reset_n(reset_n), .start(start3), .seed(seed3), .word_count(wc3),
        .busy(busy3), .done(done3), .pass(pass3), .err_count(err3),
        .first_err_addr(fea3), .first_err_data(fed3), .mem(bus3)
    );

    bit   [31:0] mem3 [16];
    logic [31:0] p3 [3];
    logic [31:0] w3_q [$];

    always @(posedge clk) begin
        if (bus3.m_chipselect && bus3.m_write) mem3[bus3.m_address] <= bus3.m_writedata;
        p3[0] <= mem3[bus3.m_address];
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign bus3.m_readdata = p3[2];

    always @(negedge clk)
        if (bus3.m_chipselect && bus3.m_write) w3_q.push_back(bus3.m_writedata);

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] fs, tmp;
        int c3, dcnt, dat;
        logic b12, b13;

        repeat (2) @(negedge clk);
        chk("rst_busy", busy1, 0);
        chk("rst_done", done1, 0);
        chk("rst_pass", pass1, 0);
        chk("rst_err", err1, 0);
        chk("rst_fea", fea1, 0);
        chk("rst_fed", fed1, 0);
        chk("rst_cs", bus1.m_chipselect, 0);
        chk("rst_wr", bus1.m_write, 0);
        chk("rst_addr", bus1.m_address, 0);
        chk("rst_wdata", bus1.m_writedata, 0);
        chk("rst_be", bus1.m_byteenable, 4'hF);
        chk("rst_clken", bus1.m_clken, 1);
        reset_n = 1'b1;
        @(negedge clk);

        run1(32'h1, 512, 0, 0, "clean");

        fs = 32'h1;
        tmp = ref_word(fs, 127);
        while (!tmp[5]) begin
            fs++;
            tmp = ref_word(fs, 127);
        end
        run1(fs, 256, 1, 0, "fault");
        run1(32'h0, 0, 0, 0, "zero_len");
        run1(32'h0, 16, 0, 0, "seed0");
        run1(32'h1234_5678, 512, 2, 0, "all_zero");
        run1(32'hDEAD_BEEF, 4, 2, 1, "saturate");
        run1($urandom, 700, 0, 0, "clamp");
        for (int k = 0; k < 3; k++) run1($urandom, int'($urandom_range(1, 100)), 0, 0, "rand");

        // reset during READ
        @(negedge clk);
        seed1 = 32'h5; wc1 = 16; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        repeat (18) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_cs", bus1.m_chipselect, 0);
        chk("mid_rst_wr", bus1.m_write, 0);
        chk("mid_rst_busy", busy1, 0);
        chk("mid_rst_addr", bus1.m_address, 0);
        chk("mid_rst_be", bus1.m_byteenable, 4'hF);
        @(negedge clk);
        reset_n = 1'b1;
        run1($urandom, 64, 0, 0, "post_rst");

        // latency 3, second start during WRITE must be ignored
        @(negedge clk);
        seed3 = 32'hACE1; wc3 = 4; start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0; c3 = 1; dcnt = 0; dat = 0; b12 = 0; b13 = 1;
        while (c3 < 20) begin
            if (c3 == 2) begin seed3 = 32'h55; wc3 = 2; start3 = 1'b1; end
            else start3 = 1'b0;
            if (done3) begin dcnt++; dat = c3; end
            if (c3 == 12) b12 = busy3;
            if (c3 == 13) b13 = busy3;
            @(negedge clk);
            c3++;
        end
        chk("l3_done_pulses", dcnt, 1);
        chk("l3_done_cyc", dat, 12);
        chk("l3_busy12", b12, 1);
        chk("l3_busy13", b13, 0);
        chk("l3_pass", pass3, 1);
        chk("l3_err", err3, 0);
        chk("l3_writes", w3_q.size(), 4);
        for (int i = 0; i < 4 && i < w3_q.size(); i++)
            chk("l3_wdata", w3_q[i], ref_word(32'hACE1, i));

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/avalon_mem_checker.md
# avalon_mem_checker

Avalon-MM master that exercises a single-port on-chip memory slave (32-bit data, byte enables, fixed read latency, no waitrequest). On `start` it fills a window of words with an LFSR pattern, reads every word back, compares, and reports pass/fail with an error count. It sits beside the Nios test system as a self-contained memory BIST driving the memory's s2 port.

## Interface
- `ADDR_WIDTH`, 9: word address width; the maximum window is 2^ADDR_WIDTH words.
- `READ_LATENCY`, 1: number of cycles from a read address cycle to the cycle in which `m_readdata` is sampled. Must be at least 1.
- `clk`  in  1: single clock.
- `reset_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: one-cycle request. It is accepted only in IDLE.
- `seed`  in  32: LFSR seed, sampled with `start`. A seed of 0 is replaced by 1.
- `word_count`  in  ADDR_WIDTH+1: number of words to test from address 0, sampled with `start`.
- `busy`  out  1: test in progress.
- `done`  out  1: one-cycle completion pulse.
- `pass`  out  1: result of the last test. Held until the next accepted `start`.
- `err_count`  out  16: number of mismatches. Saturates at 0xFFFF.
- `first_err_addr`  out  ADDR_WIDTH: address of the first mismatch.
- `first_err_data`  out  32: data read at the first mismatch.
- `m_address`  out  ADDR_WIDTH: master address.
- `m_byteenable`  out  4: master byte enables. Always 4'hF.
- `m_chipselect`  out  1: master chip select.
- `m_write`  out  1: master write strobe.
- `m_writedata`  out  32: master write data.
- `m_readdata`  in  32: master read data.
- `m_clken`  out  1: memory clock enable. Constant 1.

## Operation
- **FSM states:** IDLE, WRITE, READ, DRAIN, FINISH.
- **IDLE**
  - `start` loads the LFSR and an address counter of 0.
  - It clears `err_count`, `pass` and the capture registers.
  - If `word_count` is 0, go to FINISH. Otherwise go to WRITE.
- **WRITE**, one word per cycle:
  - `m_chipselect`=1, `m_write`=1, `m_writedata` = current LFSR value.
  - The LFSR and the address advance every cycle.
  - After the last word (address = `word_count`-1), reload the LFSR from the seed, clear the address, and go to READ.
- **READ**, one read per cycle:
  - `m_chipselect`=1, `m_write`=0.
  - The expected value enters a READ_LATENCY-deep delay line together with the address and a valid flag.
  - After the last address, go to DRAIN.
- **DRAIN:** lasts READ_LATENCY cycles, with `m_chipselect`=0. Then go to FINISH.
- **Compare:** whenever the delay-line valid flag is high, compare `m_readdata` with the delayed expected value.
  - On a mismatch, increment `err_count` (saturating).
  - On the first mismatch only, capture the address and data.
- **FINISH:** `done`=1 for one cycle and `pass` = (`err_count`==0). Then return to IDLE.
- **LFSR:** 32-bit Galois, polynomial x^32+x^22+x^2+x+1 (mask 0x80200003). Shift right; XOR the mask in when the LSB is 1.
- **`start` while busy:** ignored.
- **`word_count` above 2^ADDR_WIDTH:** clamped to 2^ADDR_WIDTH.
- **Reset mid-test:**
  - Immediate abort to IDLE.
  - `m_chipselect` and `m_write` drop asynchronously.
  - Memory contents are unspecified.
- **Reset values:** every output is 0 except `m_byteenable`=4'hF and `m_clken`=1.

## Timing
- `start` is high in cycle 0. With N = `word_count` and L = READ_LATENCY:
  - Writes occur in cycles 1..N.
  - Reads occur in cycles N+1..2N.
  - Compares occur in cycles N+1+L..2N+L.
  - `done` is high in cycle 2N+L+1.
- `busy` is high in cycles 1..2N+L+1. It is low in IDLE and low from cycle 2N+L+2.
- With N=0, `done` and `pass`=1 appear in cycle 1.
- Throughput: one transfer per cycle, with no gaps between WRITE and READ.
- The outputs `pass`, `err_count` and `first_err_*` are stable from the `done` cycle onward.

## Configuration
- **`AVALON_MEM_CHECKER_ERR_CAPTURE_EN` defined:** `first_err_addr` and `first_err_data` are registered as described in Operation.
- **Not defined:** the capture registers are removed and both outputs are tied to 0. `err_count` and `pass` are unaffected.

## Structure
- **Package `avalon_mem_checker_pkg`:**
  - The FSM state enum.
  - `LFSR_POLY` = 32'h80200003.
  - `ERR_COUNT_W` = 16.
  - A function `lfsr_next`.
- **Sub-module `avalon_mem_checker_delay`:** the parameterised READ_LATENCY-deep shift register carrying {valid, addr, expected}.

## Test plan
- **Clean pass:** seed=0x1, N=512, L=1, against the on-chip memory model.
  - Expect 512 writes, then 512 reads.
  - `done` in cycle 1026, `pass`=1, `err_count`=0.
- **Injected fault:** force bit 5 of word 0x07F stuck at 0 in the model.
  - Expect `err_count`=1 and `first_err_addr`=0x07F.
  - `first_err_data` equals the expected data with bit 5 cleared.
- **Zero length:** N=0.
  - Expect no `m_chipselect` activity.
  - `done` in cycle 1, `pass`=1.
- **Busy behaviour and latency 3:** with L=3 and N=4, pulse `start` again during WRITE.
  - The second `start` is ignored.
  - `done` occurs exactly once, in cycle 12.
- **Reset mid-operation:** assert `reset_n`=0 during READ.
  - The outputs take their reset values within the same cycle.
  - A new `start` afterwards runs a full, clean test.
- **Seed and saturation:**
  - seed=0 produces the same write data as seed=1.
  - A model that returns all zeros for N=512 gives `err_count`=512 and `pass`=0.
  - Saturation at 0xFFFF is checked by forcing the counter to 0xFFFE before two mismatches.
